xbar_cfg: RTL

XBAR_CFG -- requirements
Module: xbar_cfg

---
 rtl/xbar_cfg.sv | 112 +++++++++++
 1 files changed

// File: rtl/xbar_cfg.sv
// Serially configured crossbar: a shadow select chain is loaded one bit per
// cycle, committed atomically into the active config, and each output picks
// one crossbar input by its select field (out-of-range selects drive 0).
module xbar_cfg #(
    parameter int unsigned N_IN    = 34,
    parameter int unsigned N_OUT   = 45,
    parameter int unsigned SEL_W   = 6,
    parameter int unsigned OUT_REG = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_cfg_en,
    input  logic             io_cfg_bit,
    input  logic             io_cfg_commit,
    output logic             io_cfg_done,
    output logic             io_cfg_err,
    output logic             io_sel_oob,
    input  logic [N_IN-1:0]  io_xbar_in,
    output logic [N_OUT-1:0] io_xbar_out
);

    localparam int unsigned CFG_W = N_OUT * SEL_W;
    localparam int unsigned CNT_W = $clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);

    logic [CFG_W-1:0] shadow_q, shadow_d;
    logic [CFG_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             cfg_full;

    logic [N_OUT-1:0] mux_out;
    logic [N_OUT-1:0] oob_vec;

    assign cfg_full = (cnt_q == CNT_FULL);

    // Next-state for the config chain; commit wins over a same-cycle shift.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        if (io_cfg_commit) begin
            if (cfg_full) begin
                active_d = shadow_q;
                cnt_d    = '0;
            end else begin
                err_d = 1'b1;
            end
        end else if (io_cfg_en) begin
            shadow_d = {io_cfg_bit, shadow_q[CFG_W-1:1]};
            if (!cfg_full) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Config state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // Per-output select decode; a select matching no input flags out-of-range.
    always_comb begin
        logic [SEL_W-1:0] sel;
        sel     = '0;
        mux_out = '0;
        oob_vec = '0;
        for (int j = 0; j < int'(N_OUT); j++) begin
            sel        = active_q[j*SEL_W +: SEL_W];
            oob_vec[j] = 1'b1;
            for (int i = 0; i < int'(N_IN); i++) begin
                if (sel == SEL_W'(i)) begin
                    mux_out[j] = io_xbar_in[i];
                    oob_vec[j] = 1'b0;
                end
            end
        end
    end

    assign io_cfg_done = cfg_full;
    assign io_cfg_err  = err_q;
    assign io_sel_oob  = |oob_vec;

    if (OUT_REG != 0) begin : g_out_reg
        logic [N_OUT-1:0] out_q;

        // Whole output word registered at once, so old/new selects never mix.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                out_q <= '0;
            end else begin
                out_q <= mux_out;
            end
        end

        assign io_xbar_out = out_q;
    end else begin : g_out_comb
        assign io_xbar_out = mux_out;
    end

endmodule
